dac_frame_sequencer: RTL and testbench

Upstream feeder for the I2C DAC master. Holds 16 channel codes (2 octal DACs x 8 channels), and on a frame request emits one 32-bit I2C transaction word per channel over a valid/ready handshake. Before the first frame after reset it issues one power-up word per DAC. Once every channel is acknowledged, it pulses LDAC low so all outputs update together.

---
 rtl/dac_pkg.sv | 29 ++
 rtl/dac_word_builder.sv | 27 ++
 rtl/dac_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dac_frame_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC frame sequencer, its word builder and the I2C master.
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PWRUP = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    LDAC  = 3'd4
  } state_e;

  localparam int ADDR_W = 8;
  localparam int CMD_W  = 8;
  localparam int CODE_W = 12;
  localparam int WORD_W = 32;
  localparam int NUM_CH = 16;
  localparam int IDX_W  = 4;

  localparam logic [7:0]  DAC1_ADDR_DEF = 8'h54;
  localparam logic [7:0]  DAC2_ADDR_DEF = 8'h56;
  localparam logic [7:0]  CMD_BASE_DEF  = 8'h08;
  localparam logic [7:0]  PWR_CMD_DEF   = 8'h40;
  localparam logic [15:0] PWR_DATA_DEF  = 16'h0000;

  function automatic logic [7:0] ch_cmd(input logic [7:0] base, input logic [3:0] idx);
    return base | {5'b00000, idx[2:0]};
  endfunction

endpackage

// File: rtl/dac_word_builder.sv
// Formats one 32-bit I2C transaction word from phase, channel index and code.
module dac_word_builder
  import dac_pkg::*;
#(
  parameter logic [7:0]  DAC1_ADDR = DAC1_ADDR_DEF,
  parameter logic [7:0]  DAC2_ADDR = DAC2_ADDR_DEF,
  parameter logic [7:0]  CMD_BASE  = CMD_BASE_DEF,
  parameter logic [7:0]  PWR_CMD   = PWR_CMD_DEF,
  parameter logic [15:0] PWR_DATA  = PWR_DATA_DEF
) (
  input  logic              pwrup,
  input  logic [IDX_W-1:0]  idx,
  input  logic [CODE_W-1:0] code,
  output logic [WORD_W-1:0] word
);

  // Power-up words use idx[0] to pick the DAC; channel words use idx[3].
  always_comb begin
    word = 32'h0000_0000;
    if (pwrup) begin
      word = {(idx[0] ? DAC2_ADDR : DAC1_ADDR), PWR_CMD, PWR_DATA};
    end else begin
      word = {(idx[3] ? DAC2_ADDR : DAC1_ADDR), ch_cmd(CMD_BASE, idx), code, 4'h0};
    end
  end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Streams one I2C word per DAC channel (after optional power-up words) and
// strobes LDAC once the whole frame has been acknowledged.
module dac_frame_sequencer
  import dac_pkg::*;
#(
  parameter logic [7:0]  DAC1_ADDR   = DAC1_ADDR_DEF,
  parameter logic [7:0]  DAC2_ADDR   = DAC2_ADDR_DEF,
  parameter logic [7:0]  CMD_BASE    = CMD_BASE_DEF,
  parameter logic [7:0]  PWR_CMD     = PWR_CMD_DEF,
  parameter logic [15:0] PWR_DATA    = PWR_DATA_DEF,
  parameter bit          PWRUP_EN    = 1'b1,
  parameter int          LDAC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ch_wr_en,
  input  logic [IDX_W-1:0]  ch_wr_addr,
  input  logic [CODE_W-1:0] ch_wr_data,
  input  logic              frame_start,
  output logic              txn_valid,
  output logic [WORD_W-1:0] txn_word,
  input  logic              txn_ready,
  input  logic              txn_done,
  input  logic              txn_error,
  output logic              ldac_n,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_error,
  output logic              err_sticky,
  output logic              overrun
);

  localparam int CNT_W = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LDAC_LOAD = CNT_W'(LDAC_CYCLES - 1);

  state_e             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               powered_r;
  logic               pwr_phase_r;
  logic [CNT_W-1:0]   ldac_cnt_r;
  logic [CODE_W-1:0]  shadow_r [NUM_CH];
  logic [CODE_W-1:0]  frame_r  [NUM_CH];

  logic               start_pwr_s;
  logic [IDX_W-1:0]   idx_inc_s;
  logic               bld_pwr_s;
  logic [IDX_W-1:0]   bld_idx_s;
  logic [CODE_W-1:0]  bld_code_s;
  logic [WORD_W-1:0]  bld_word_s;

  assign start_pwr_s = PWRUP_EN & ~powered_r;
  assign idx_inc_s   = idx_r + 4'd1;

  // Select the word that will be presented next, so it can be registered on the transition.
  always_comb begin
    bld_pwr_s  = 1'b0;
    bld_idx_s  = idx_r;
    bld_code_s = frame_r[idx_r];
    case (state_r)
      IDLE: begin
        bld_pwr_s  = start_pwr_s;
        bld_idx_s  = 4'd0;
        bld_code_s = shadow_r[0];
      end
      WAIT: begin
        if (pwr_phase_r) begin
          bld_pwr_s  = (idx_r != 4'd1);
          bld_idx_s  = (idx_r == 4'd1) ? 4'd0 : 4'd1;
          bld_code_s = frame_r[0];
        end else begin
          bld_pwr_s  = 1'b0;
          bld_idx_s  = idx_inc_s;
          bld_code_s = frame_r[idx_inc_s];
        end
      end
      default: begin
        bld_pwr_s  = 1'b0;
        bld_idx_s  = idx_r;
        bld_code_s = frame_r[idx_r];
      end
    endcase
  end

  dac_word_builder #(
    .DAC1_ADDR (DAC1_ADDR),
    .DAC2_ADDR (DAC2_ADDR),
    .CMD_BASE  (CMD_BASE),
    .PWR_CMD   (PWR_CMD),
    .PWR_DATA  (PWR_DATA)
  ) u_builder (
    .pwrup (bld_pwr_s),
    .idx   (bld_idx_s),
    .code  (bld_code_s),
    .word  (bld_word_s)
  );

  // Channel shadow registers, writable in every state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) shadow_r[i] <= 12'h000;
    end else if (ch_wr_en) begin
      shadow_r[ch_wr_addr] <= ch_wr_data;
    end
  end

  // Frame sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      idx_r       <= 4'd0;
      powered_r   <= 1'b0;
      pwr_phase_r <= 1'b0;
      ldac_cnt_r  <= '0;
      txn_valid   <= 1'b0;
      txn_word    <= 32'h0000_0000;
      ldac_n      <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      err_sticky  <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) frame_r[i] <= 12'h000;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (frame_start && (state_r != IDLE)) overrun <= 1'b1;
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            frame_r     <= shadow_r;
            idx_r       <= 4'd0;
            pwr_phase_r <= start_pwr_s;
            err_sticky  <= 1'b0;
            busy        <= 1'b1;
            txn_valid   <= 1'b1;
            txn_word    <= bld_word_s;
            state_r     <= start_pwr_s ? PWRUP : ISSUE;
          end
        end
        PWRUP, ISSUE: begin
          if (txn_valid && txn_ready) begin
            txn_valid <= 1'b0;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (txn_error) begin
            state_r     <= IDLE;
            busy        <= 1'b0;
            frame_error <= 1'b1;
            err_sticky  <= 1'b1;
            pwr_phase_r <= 1'b0;
          end else if (txn_done) begin
            if (pwr_phase_r && (idx_r == 4'd1)) begin
              powered_r   <= 1'b1;
              pwr_phase_r <= 1'b0;
              idx_r       <= 4'd0;
              txn_valid   <= 1'b1;
              txn_word    <= bld_word_s;
              state_r     <= ISSUE;
            end else if (pwr_phase_r) begin
              idx_r     <= 4'd1;
              txn_valid <= 1'b1;
              txn_word  <= bld_word_s;
              state_r   <= PWRUP;
            end else if (idx_r == 4'd15) begin
              ldac_n     <= 1'b0;
              ldac_cnt_r <= LDAC_LOAD;
              state_r    <= LDAC;
            end else begin
              idx_r     <= idx_inc_s;
              txn_valid <= 1'b1;
              txn_word  <= bld_word_s;
              state_r   <= ISSUE;
            end
          end
        end
        LDAC: begin
          if (ldac_cnt_r == '0) begin
            ldac_n     <= 1'b1;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end else begin
            ldac_cnt_r <= ldac_cnt_r - CNT_W'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Randomized bench for dac_frame_sequencer with a queue-based frame model and directed scenarios.
module tb_dac_frame_sequencer;

  localparam int LDAC_LEN = 4;

  logic        clk = 1'b0;
  logic        resetn, ch_wr_en, frame_start, txn_ready, txn_done, txn_error;
  logic [3:0]  ch_wr_addr;
  logic [11:0] ch_wr_data;
  logic        txn_valid, ldac_n, busy, frame_done, frame_error, err_sticky, overrun;
  logic [31:0] txn_word;

  always #5 clk = ~clk;

  dac_frame_sequencer dut (
    .clk(clk), .resetn(resetn), .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr),
    .ch_wr_data(ch_wr_data), .frame_start(frame_start), .txn_valid(txn_valid),
    .txn_word(txn_word), .txn_ready(txn_ready), .txn_done(txn_done), .txn_error(txn_error),
    .ldac_n(ldac_n), .busy(busy), .frame_done(frame_done), .frame_error(frame_error),
    .err_sticky(err_sticky), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending words of the current frame plus a few flags.
  logic [11:0] m_shadow [16];
  bit          m_powered, m_busy, m_valid, m_await, m_sticky, m_ovr, m_fdone, m_ferr;
  int          m_ldac;
  logic [31:0] m_cur;
  logic [31:0] m_q [$];

  logic [31:0] dut_log [$];
  int          ldac_low_cnt, fdone_cnt, ferr_cnt;
  int          rdy_pct = 100;
  int          done_pct = 100;
  bit          stall = 1'b0;
  logic [15:0] err_key = 16'hFFFF;

  function automatic logic [31:0] chan_word(int ch, logic [11:0] code);
    return {((ch < 8) ? 8'h54 : 8'h56), 8'h08 + 8'(ch % 8), code, 4'h0};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    m_fdone = 1'b0;
    m_ferr  = 1'b0;
    if (!resetn) begin
      for (int i = 0; i < 16; i++) m_shadow[i] = 12'h000;
      m_powered = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_await = 1'b0;
      m_sticky = 1'b0; m_ovr = 1'b0; m_ldac = 0; m_cur = 32'h0;
      m_q.delete();
      return;
    end
    if (frame_start && m_busy) m_ovr = 1'b1;
    if (m_ldac > 0) begin
      m_ldac--;
      if (m_ldac == 0) begin m_fdone = 1'b1; m_busy = 1'b0; end
    end else if (m_valid) begin
      if (txn_ready) begin m_valid = 1'b0; m_await = 1'b1; end
    end else if (m_await) begin
      if (txn_error) begin
        m_await = 1'b0; m_busy = 1'b0; m_ferr = 1'b1; m_sticky = 1'b1;
        m_q.delete();
      end else if (txn_done) begin
        m_await = 1'b0;
        if (m_cur == 32'h5640_0000) m_powered = 1'b1;
        if (m_q.size() == 0) m_ldac = LDAC_LEN;
        else begin m_cur = m_q.pop_front(); m_valid = 1'b1; end
      end
    end else if (!m_busy && frame_start) begin
      if (!m_powered) begin
        m_q.push_back(32'h5440_0000);
        m_q.push_back(32'h5640_0000);
      end
      for (int ch = 0; ch < 16; ch++) m_q.push_back(chan_word(ch, m_shadow[ch]));
      m_cur = m_q.pop_front();
      m_valid = 1'b1; m_busy = 1'b1; m_sticky = 1'b0;
    end
    if (ch_wr_en) m_shadow[ch_wr_addr] = ch_wr_data;
  endfunction

  task automatic compare();
    logic [6:0] exp_v, act_v;
    exp_v = {m_valid, (m_ldac == 0), m_busy, m_fdone, m_ferr, m_sticky, m_ovr};
    act_v = {txn_valid, ldac_n, busy, frame_done, frame_error, err_sticky, overrun};
    check("outputs{valid,ldac_n,busy,done,err,sticky,ovr}", {25'h0, act_v}, {25'h0, exp_v});
    if (m_valid) check("txn_word", txn_word, m_cur);
    if (!ldac_n) ldac_low_cnt++;
    if (frame_done) fdone_cnt++;
    if (frame_error) ferr_cnt++;
  endtask

  // One clock: responder decides, edge, model update, sample at the falling edge.
  task automatic tick();
    txn_ready = !stall && ($urandom_range(0, 99) < rdy_pct);
    txn_done  = 1'b0;
    txn_error = 1'b0;
    if (m_await && ($urandom_range(0, 99) < done_pct)) begin
      if (m_cur[31:16] == err_key) txn_error = 1'b1;
      else txn_done = 1'b1;
    end
    if (txn_valid && txn_ready) dut_log.push_back(txn_word);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    frame_start = 1'b0;
    ch_wr_en    = 1'b0;
  endtask

  task automatic write_ch(logic [3:0] a, logic [11:0] d);
    ch_wr_en = 1'b1; ch_wr_addr = a; ch_wr_data = d;
    tick();
  endtask

  task automatic clear_stats();
    dut_log.delete();
    ldac_low_cnt = 0; fdone_cnt = 0; ferr_cnt = 0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
  endtask

  task automatic run_idle(int max_cycles);
    int n = 0;
    while (m_busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("frame_timeout", {31'h0, m_busy}, 32'h0);
  endtask

  initial begin
    logic [31:0] tmp_w;
    int n;
    resetn = 1'b0; ch_wr_en = 1'b0; ch_wr_addr = 4'h0; ch_wr_data = 12'h000;
    frame_start = 1'b0; txn_ready = 1'b0; txn_done = 1'b0; txn_error = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("reset_word", txn_word, 32'h0);
    check("reset_ldac_n", {31'h0, ldac_n}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    resetn = 1'b1;
    tick();

    // 1: first frame with power-up words
    write_ch(4'd0, 12'hABC);
    clear_stats();
    start_frame();
    run_idle(500);
    check("t1_nwords", dut_log.size(), 32'd18);
    check("t1_w0", dut_log[0], 32'h5440_0000);
    check("t1_w1", dut_log[1], 32'h5640_0000);
    check("t1_w2", dut_log[2], 32'h5408_ABC0);
    check("t1_w3", dut_log[3], 32'h5409_0000);
    check("t1_w17", dut_log[17], 32'h560F_0000);
    check("t1_ldac_low", ldac_low_cnt, 32'd4);
    check("t1_frame_done", fdone_cnt, 32'd1);

    // 2: no power-up on the second frame
    write_ch(4'd9, 12'h123);
    clear_stats();
    start_frame();
    run_idle(500);
    check("t2_nwords", dut_log.size(), 32'd16);
    check("t2_w0", dut_log[0], 32'h5408_ABC0);
    check("t2_w9", dut_log[9], 32'h5609_1230);

    // 3: ready withheld for 20 cycles
    clear_stats();
    stall = 1'b1;
    start_frame();
    for (int i = 0; i < 20; i++) tick();
    check("t3_no_handshake", dut_log.size(), 32'd0);
    check("t3_word_held", txn_word, 32'h5408_ABC0);
    check("t3_valid_held", {31'h0, txn_valid}, 32'h1);
    stall = 1'b0;
    run_idle(500);

    // 4: error on channel 5
    err_key = 16'h540D;
    clear_stats();
    start_frame();
    run_idle(500);
    check("t4_nwords", dut_log.size(), 32'd6);
    check("t4_sticky", {31'h0, err_sticky}, 32'h1);
    check("t4_ldac_never", ldac_low_cnt, 32'd0);
    check("t4_frame_error", ferr_cnt, 32'd1);
    err_key = 16'hFFFF;
    clear_stats();
    start_frame();
    check("t4_sticky_cleared", {31'h0, err_sticky}, 32'h0);
    run_idle(500);
    check("t4_restart_w0", dut_log[0], 32'h5408_ABC0);

    // 5: overrun and mid-frame shadow write
    clear_stats();
    start_frame();
    n = 0;
    while (!m_await && n < 50) begin tick(); n++; end
    frame_start = 1'b1; ch_wr_en = 1'b1; ch_wr_addr = 4'd3; ch_wr_data = 12'hFFF;
    tick();
    check("t5_overrun", {31'h0, overrun}, 32'h1);
    run_idle(500);
    check("t5_old_ch3", dut_log[3], 32'h540B_0000);
    clear_stats();
    start_frame();
    run_idle(500);
    check("t5_new_ch3", dut_log[3], 32'h540B_FFF0);

    // 6: reset while LDAC is low
    clear_stats();
    start_frame();
    n = 0;
    while (m_ldac == 0 && n < 200) begin tick(); n++; end
    resetn = 1'b0;
    tick();
    check("t6_ldac_released", {31'h0, ldac_n}, 32'h1);
    check("t6_no_frame_done", fdone_cnt, 32'd0);
    resetn = 1'b1;
    tick();
    clear_stats();
    start_frame();
    run_idle(500);
    check("t6_pwrup_again", dut_log[0], 32'h5440_0000);
    check("t6_nwords", dut_log.size(), 32'd18);

    // Random traffic: slow ready/done, writes, spurious starts, occasional errors
    rdy_pct = 60;
    done_pct = 40;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        tmp_w = chan_word($urandom_range(0, 15), 12'h000);
        err_key = tmp_w[31:16];
      end else begin
        err_key = 16'hFFFF;
      end
      start_frame();
      n = 0;
      while (m_busy && n < 2000) begin
        if ($urandom_range(0, 99) < 20) begin
          ch_wr_en = 1'b1;
          ch_wr_addr = 4'($urandom_range(0, 15));
          ch_wr_data = 12'($urandom);
        end
        if ($urandom_range(0, 99) < 3) frame_start = 1'b1;
        tick();
        n++;
      end
      check("rand_frame_timeout", {31'h0, m_busy}, 32'h0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          ch_wr_en = 1'b1;
          ch_wr_addr = 4'($urandom_range(0, 15));
          ch_wr_data = 12'($urandom);
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
